// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants and helpers for the button conditioner.
//   CLK_HZ      : board system clock frequency
//   TICK_1MS    : prescaler division giving a 1 ms debounce tick at CLK_HZ
//   clog2_min1  : counter width needed to hold values 0..value-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package button_pkg;

    localparam int CLK_HZ   = 100_000_000;
    localparam int TICK_1MS = CLK_HZ / 1000;

    // Smallest width w >= 1 with 2**w >= value.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One conditioned button: 2-FF synchroniser, polarity correction, tick-timed
// debounce, registered press/release pulses and long-press / auto-repeat pulses.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : shared debounce tick strobe from the top-level prescaler
//   raw          : raw asynchronous button input
//   level        : debounced pressed state (1 = pressed)
//   rise / fall  : one-clk pulse on accepted press / release
//   hold         : one-clk pulse on long press and on each auto-repeat
// -----------------------------------------------------------------------------
module button_channel
    import button_pkg::*;
#(
    parameter int   DEBOUNCE_TICKS = 10,
    parameter int   HOLD_TICKS     = 1000,
    parameter int   REPEAT_TICKS   = 200,
    parameter logic ACTIVE_LOW     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int DW = clog2_min1(DEBOUNCE_TICKS);
    localparam int HW = clog2_min1(HOLD_TICKS + 1);

    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);
    // With repeat enabled the counter restarts REPEAT_TICKS short of the
    // threshold; without it the counter parks at the threshold (no re-fire).
    localparam logic [HW-1:0] HOLD_RELOAD = (REPEAT_TICKS > 0) ?
                                            HW'(HOLD_TICKS - REPEAT_TICKS) :
                                            HW'(HOLD_TICKS);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic [DW-1:0] db_cnt_r;
    logic [HW-1:0] hold_cnt_r;
    logic          rise_r;
    logic          fall_r;
    logic          hold_r;
    logic          sample_s;
    logic          accept_s;

    // Synchroniser; preset to the inactive raw level so reset never looks like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= ACTIVE_LOW;
            sync2_r <= ACTIVE_LOW;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Polarity correction and detection of the tick that completes a debounce.
    always_comb begin
        sample_s = sync2_r ^ ACTIVE_LOW;
        accept_s = 1'b0;
        if ((sample_s != stable_r) && tick && (db_cnt_r == DB_LAST)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Debounce counter, stable state and registered edge pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt_r <= {DW{1'b0}};
            stable_r <= 1'b0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            rise_r <= accept_s & sample_s;
            fall_r <= accept_s & ~sample_s;
            if (sample_s == stable_r) begin
                // Any agreeing cycle restarts the count.
                db_cnt_r <= {DW{1'b0}};
            end else if (tick) begin
                if (accept_s) begin
                    stable_r <= sample_s;
                    db_cnt_r <= {DW{1'b0}};
                end else begin
                    db_cnt_r <= db_cnt_r + DW'(1);
                end
            end
        end
    end

    // Hold counter: idle while released, and both the press-accept tick and the
    // release-accept cycle leave it at zero with no hold pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_r <= {HW{1'b0}};
            hold_r     <= 1'b0;
        end else begin
            hold_r <= 1'b0;
            if (!stable_r || accept_s) begin
                hold_cnt_r <= {HW{1'b0}};
            end else if (tick) begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_r     <= 1'b1;
                    hold_cnt_r <= HOLD_RELOAD;
                end else if (hold_cnt_r != HOLD_MAX) begin
                    hold_cnt_r <= hold_cnt_r + HW'(1);
                end
            end
        end
    end

    assign level = stable_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign hold  = hold_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Multi-channel push-button conditioner. One shared prescaler produces the
// debounce tick; each channel is an independent button_channel.
// Ports:
//   clk       : system clock
//   reset_n   : asynchronous active-low reset
//   btn_raw   : raw asynchronous button inputs            [NUM_CH]
//   btn_level : debounced pressed state (after polarity)   [NUM_CH]
//   btn_rise  : one-clk pulse on accepted press            [NUM_CH]
//   btn_fall  : one-clk pulse on accepted release          [NUM_CH]
//   btn_hold  : one-clk pulse on long press / auto-repeat  [NUM_CH]
//   tick      : shared debounce tick strobe
// -----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int                NUM_CH          = 5,
    parameter int                TICK_DIV        = TICK_1MS,
    parameter int                DEBOUNCE_TICKS  = 10,
    parameter int                HOLD_TICKS      = 1000,
    parameter int                REPEAT_TICKS    = 200,
    parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_raw,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_hold,
    output logic              tick
);

    localparam int            PW       = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_cnt_r;
    logic          tick_r;

    // Shared prescaler; the tick is registered so it is low during and right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= {PW{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            tick_r <= (pre_cnt_r == PRE_LAST);
            if (pre_cnt_r == PRE_LAST) begin
                pre_cnt_r <= {PW{1'b0}};
            end else begin
                pre_cnt_r <= pre_cnt_r + PW'(1);
            end
        end
    end

    assign tick = tick_r;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .HOLD_TICKS     (HOLD_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS),
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[i])
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick_r),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .rise    (btn_rise[i]),
            .fall    (btn_fall[i]),
            .hold    (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
// Two instances share clock, reset and raw inputs: dut_a repeats holds every
// 5 ticks, dut_b has repeat disabled. Stimulus pushes expected pulse events
// (with an allowed cycle window) into per-DUT queues; a negedge monitor pops
// and compares whenever a DUT shows any pulse, and also checks levels, the
// tick period and the all-zero outputs while reset is asserted.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    typedef struct {
        int         lo;
        int         hi;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] h;
    } ev_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn_raw = 4'b1000;

    logic [3:0] level_a, rise_a, fall_a, hold_a;
    logic [3:0] level_b, rise_b, fall_b, hold_b;
    logic       tick_a, tick_b;

    int  cyc       = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  last_tick = -1;
    bit  done      = 1'b0;
    ev_t qa[$];
    ev_t qb[$];
    logic [3:0] lvl_a = 4'b0000;
    logic [3:0] lvl_b = 4'b0000;

    button_conditioner #(
        .NUM_CH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10),
        .REPEAT_TICKS(5), .ACTIVE_LOW_MASK(4'b1000)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(level_a), .btn_rise(rise_a), .btn_fall(fall_a),
        .btn_hold(hold_a), .tick(tick_a)
    );

    button_conditioner #(
        .NUM_CH(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .HOLD_TICKS(10),
        .REPEAT_TICKS(0), .ACTIVE_LOW_MASK(4'b1000)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_level(level_b), .btn_rise(rise_b), .btn_fall(fall_b),
        .btn_hold(hold_b), .tick(tick_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(input string who, input ev_t e, input logic [3:0] r,
                            input logic [3:0] f, input logic [3:0] h, input int t,
                            output bit bad);
        bad = (r !== e.r) || (f !== e.f) || (h !== e.h) || (t < e.lo) || (t > e.hi);
        if (bad)
            $display("FAIL %s_event: got rise=%b fall=%b hold=%b at cyc %0d, required rise=%b fall=%b hold=%b in cyc %0d..%0d",
                     who, r, f, h, t, e.r, e.f, e.h, e.lo, e.hi);
    endtask

    // Queue an expected event for dut_a and/or dut_b.
    task automatic push(input bit to_a, input bit to_b, input int lo, input int hi,
                        input logic [3:0] r, input logic [3:0] f, input logic [3:0] h);
        ev_t e;
        e.lo = lo; e.hi = hi; e.r = r; e.f = f; e.h = h;
        if (to_a) qa.push_back(e);
        if (to_b) qb.push_back(e);
    endtask

    // Change the raw inputs just after a clock edge; c0 is that edge's cycle number.
    task automatic drive(input logic [3:0] v, output int c0);
        @(posedge clk);
        #1;
        btn_raw = v;
        c0 = cyc;
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        bit  bad;
        if (!reset_n) begin
            lvl_a = 4'b0000;
            lvl_b = 4'b0000;
            last_tick = -1;
            n_cmp++;
            if ((level_a | rise_a | fall_a | hold_a | level_b | rise_b | fall_b | hold_b) !== 4'b0000 ||
                tick_a !== 1'b0 || tick_b !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: cyc %0d a lvl=%b r=%b f=%b h=%b t=%b b lvl=%b r=%b f=%b h=%b t=%b, required all 0",
                         cyc, level_a, rise_a, fall_a, hold_a, tick_a, level_b, rise_b, fall_b, hold_b, tick_b);
            end
        end else begin
            if ((rise_a | fall_a | hold_a) != 4'b0000) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut_a_unexpected: rise=%b fall=%b hold=%b at cyc %0d, required no pulse",
                             rise_a, fall_a, hold_a, cyc);
                end else begin
                    e = qa.pop_front();
                    check_ev("dut_a", e, rise_a, fall_a, hold_a, cyc, bad);
                    if (bad) n_bad++;
                    lvl_a = (lvl_a | e.r) & ~e.f;
                end
            end
            if ((rise_b | fall_b | hold_b) != 4'b0000) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut_b_unexpected: rise=%b fall=%b hold=%b at cyc %0d, required no pulse",
                             rise_b, fall_b, hold_b, cyc);
                end else begin
                    e = qb.pop_front();
                    check_ev("dut_b", e, rise_b, fall_b, hold_b, cyc, bad);
                    if (bad) n_bad++;
                    lvl_b = (lvl_b | e.r) & ~e.f;
                end
            end
            n_cmp++;
            if (level_a !== lvl_a || level_b !== lvl_b) begin
                n_bad++;
                $display("FAIL level: cyc %0d got a=%b b=%b, required a=%b b=%b", cyc, level_a, level_b, lvl_a, lvl_b);
            end
            if (tick_a === 1'b1) begin
                if (last_tick >= 0) begin
                    n_cmp++;
                    if (cyc - last_tick != 4) begin
                        n_bad++;
                        $display("FAIL tick_period: got %0d clk at cyc %0d, required 4", cyc - last_tick, cyc);
                    end
                end
                last_tick = cyc;
            end
            if (done) begin
                n_cmp++;
                if (qa.size() != 0 || qb.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_events: got %0d/%0d events still pending (a/b), required 0/0", qa.size(), qb.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin : stimulus
        int c0;
        // 1. Reset and idle
        reset_n = 1'b0;
        btn_raw = 4'b1000;
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (200) @(posedge clk);

        // 2. Clean press / release on channel 0
        drive(4'b1001, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0001, 4'b0000, 4'b0000);
        repeat (29) @(posedge clk);
        drive(4'b1000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0000, 4'b0001, 4'b0000);
        repeat (30) @(posedge clk);

        // 3. Glitch (8 clk) then a bounce train toggling every 3 clk, then settle high
        drive(4'b1010, c0);
        repeat (7) @(posedge clk);
        drive(4'b1000, c0);
        repeat (30) @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            drive(((k % 2) == 0) ? 4'b1010 : 4'b1000, c0);
            repeat (2) @(posedge clk);
        end
        drive(4'b1010, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0010, 4'b0000, 4'b0000);
        repeat (29) @(posedge clk);
        drive(4'b1000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0000, 4'b0010, 4'b0000);
        repeat (30) @(posedge clk);

        // 4. Active-low channel 3
        drive(4'b0000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b1000, 4'b0000, 4'b0000);
        repeat (29) @(posedge clk);
        drive(4'b1000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0000, 4'b1000, 4'b0000);
        repeat (30) @(posedge clk);

        // 5. Long press on channel 2: holds 40 clk after acceptance, then every 20 clk
        drive(4'b1100, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0100, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++)
            push(1'b1, 1'b0, c0 + 51 + 20 * k, c0 + 54 + 20 * k, 4'b0000, 4'b0000, 4'b0100);
        push(1'b0, 1'b1, c0 + 51, c0 + 54, 4'b0000, 4'b0000, 4'b0100);
        repeat (149) @(posedge clk);
        drive(4'b1000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0000, 4'b0100, 4'b0000);
        repeat (60) @(posedge clk);

        // 6. Reset mid-operation with channels 0 and 2 held
        drive(4'b1101, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0101, 4'b0000, 4'b0000);
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        c0 = cyc;
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0101, 4'b0000, 4'b0000);
        repeat (30) @(posedge clk);
        drive(4'b1000, c0);
        push(1'b1, 1'b1, c0 + 11, c0 + 14, 4'b0000, 4'b0101, 4'b0000);
        repeat (30) @(posedge clk);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL watchdog: monitor did not close the run, required summary within 5 clk");
        $fatal(1, "monitor did not finish");
    end

endmodule
